// File: rtl/card_pkg.sv
// Shared types, constants and card-field helpers for the card shoe and its neighbours.
package card_pkg;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  localparam int RANK_W         = 4;
  localparam int SUIT_W         = 2;
  localparam int SLOT_W         = RANK_W + SUIT_W;
  localparam int CARDS_PER_DECK = 52;
  localparam int RANKS          = 13;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Pack suit and rank into the 6-bit slot stored in the shoe.
  function automatic logic [SLOT_W-1:0] pack_slot(input logic [SUIT_W-1:0] suit,
                                                  input logic [RANK_W-1:0] rank);
    return {suit, rank};
  endfunction

  // Widen a stored slot to the 8-bit card code seen by the hand logic.
  function automatic logic [7:0] slot_to_card(input logic [SLOT_W-1:0] slot);
    return {2'b00, slot};
  endfunction

  // Extract the rank (1=Ace .. 13=King) from a card code.
  function automatic logic [RANK_W-1:0] card_rank(input logic [7:0] code);
    return code[RANK_W-1:0];
  endfunction

  // Extract the suit (0..3) from a card code.
  function automatic logic [SUIT_W-1:0] card_suit(input logic [7:0] code);
    return code[SLOT_W-1:RANK_W];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR with load and step; shared by the random sources.
module lfsr16
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = LFSR_TAPS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] lfsr_r;
  logic [15:0] next_s;

  // One Galois step: shift right and fold in the taps when a one drops out of bit 0.
  always_comb begin
    if (lfsr_r[0]) begin
      next_s = (lfsr_r >> 1) ^ TAPS;
    end else begin
      next_s = lfsr_r >> 1;
    end
  end

  // LFSR state register; a load overrides a step in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= load_value;
    end else if (step) begin
      lfsr_r <= next_s;
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/card_shoe.sv
// Multi-deck card shoe: ordered fill, in-place Fisher-Yates shuffle, one-card-per-request deal.
module card_shoe
  import card_pkg::*;
#(
  parameter int          NUM_DECKS   = 1,
  parameter int          PENETRATION = (3 * CARDS_PER_DECK * NUM_DECKS) / 4,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                                             clk,
  input  logic                                             reset_n,
  input  logic                                             shuffle_start,
  input  logic [15:0]                                      seed,
  input  logic                                             deal_req,
  output logic [7:0]                                       card,
  output logic                                             card_valid,
  output logic                                             empty_err,
  output logic                                             busy,
  output logic [$clog2(CARDS_PER_DECK*NUM_DECKS+1)-1:0]    cards_left,
  output logic                                             shoe_low
);

  localparam int D     = CARDS_PER_DECK * NUM_DECKS;
  localparam int CL_W  = $clog2(D + 1);
  localparam int IDX_W = $clog2(D);
  localparam int PW    = 17 + IDX_W;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(D - 1);
  localparam logic [IDX_W-1:0]  ONE_IDX  = IDX_W'(1);
  localparam logic [CL_W-1:0]   D_CL     = CL_W'(D);
  localparam logic [CL_W-1:0]   PEN_CL   = CL_W'(PENETRATION);
  localparam logic [RANK_W-1:0] RANK_MAX = 4'd13;

  state_t              state_r, next_state_s;
  logic [SLOT_W-1:0]   slots_r [D];
  logic [IDX_W-1:0]    fill_idx_r, shuf_i_r, ptr_r, j_s;
  logic [IDX_W:0]      i_plus1_s;
  logic [RANK_W-1:0]   rank_r;
  logic [SUIT_W-1:0]   suit_r;
  logic [CL_W-1:0]     cards_left_r;
  logic                shoe_low_r;
  logic [7:0]          card_r;
  logic                card_valid_r, empty_err_r, busy_r;
  logic                shuf_go_s, deal_go_s, empty_go_s, lfsr_step_s;
  logic [15:0]         lfsr_s, lfsr_seed_s;

  // A zero seed would lock the LFSR, so it falls back to the build-time seed.
  always_comb begin
    if (seed == 16'h0000) begin
      lfsr_seed_s = SEED;
    end else begin
      lfsr_seed_s = seed;
    end
  end

  lfsr16 #(.SEED(SEED), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (shuf_go_s),
    .load_value (lfsr_seed_s),
    .step       (lfsr_step_s),
    .value      (lfsr_s)
  );

  // Swap partner j = (lfsr * (i+1)) >> 16 always lands in 0..i without a divider.
  always_comb begin
    i_plus1_s = {1'b0, shuf_i_r} + {{IDX_W{1'b0}}, 1'b1};
    j_s       = IDX_W'((PW'(lfsr_s) * PW'(i_plus1_s)) >> 5'd16);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (fill_idx_r == LAST_IDX) next_state_s = ST_SHUFFLE;
        else                        next_state_s = ST_FILL;
      end
      ST_SHUFFLE: begin
        if (shuf_i_r == ONE_IDX) next_state_s = ST_READY;
        else                     next_state_s = ST_SHUFFLE;
      end
      ST_READY: begin
        if (shuf_go_s) next_state_s = ST_FILL;
        else           next_state_s = ST_READY;
      end
      default: next_state_s = ST_FILL;
    endcase
  end

  // FSM output decode: requests only act in READY, and a shuffle beats a deal.
  always_comb begin
    shuf_go_s   = 1'b0;
    deal_go_s   = 1'b0;
    empty_go_s  = 1'b0;
    lfsr_step_s = 1'b0;
    case (state_r)
      ST_READY: begin
        if (shuffle_start) begin
          shuf_go_s = 1'b1;
        end else if (deal_req) begin
          if (cards_left_r != {CL_W{1'b0}}) deal_go_s  = 1'b1;
          else                              empty_go_s = 1'b1;
        end else begin
          shuf_go_s = 1'b0;
        end
      end
      ST_SHUFFLE: lfsr_step_s = 1'b1;
      default:    lfsr_step_s = 1'b0;
    endcase
  end

  // Card store and deal bookkeeping: fill with wrap counters, swap two slots, pop on deal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < D; k++) slots_r[k] <= '0;
      fill_idx_r   <= '0;
      shuf_i_r     <= '0;
      ptr_r        <= '0;
      rank_r       <= 4'd1;
      suit_r       <= 2'd0;
      cards_left_r <= '0;
      shoe_low_r   <= 1'b0;
      card_r       <= 8'd0;
    end else begin
      case (state_r)
        ST_FILL: begin
          slots_r[fill_idx_r] <= pack_slot(suit_r, rank_r);
          if (rank_r == RANK_MAX) begin
            rank_r <= 4'd1;
            suit_r <= suit_r + 2'd1;
          end else begin
            rank_r <= rank_r + 4'd1;
          end
          if (fill_idx_r == LAST_IDX) begin
            fill_idx_r <= '0;
            shuf_i_r   <= LAST_IDX;
          end else begin
            fill_idx_r <= fill_idx_r + ONE_IDX;
          end
        end
        ST_SHUFFLE: begin
          slots_r[shuf_i_r] <= slots_r[j_s];
          slots_r[j_s]      <= slots_r[shuf_i_r];
          shuf_i_r          <= shuf_i_r - ONE_IDX;
          if (shuf_i_r == ONE_IDX) begin
            ptr_r        <= '0;
            cards_left_r <= D_CL;
            shoe_low_r   <= 1'b0;
          end
        end
        ST_READY: begin
          if (shuf_go_s) begin
            fill_idx_r   <= '0;
            rank_r       <= 4'd1;
            suit_r       <= 2'd0;
            cards_left_r <= '0;
            shoe_low_r   <= 1'b0;
          end else if (deal_go_s) begin
            card_r       <= slot_to_card(slots_r[ptr_r]);
            ptr_r        <= ptr_r + ONE_IDX;
            cards_left_r <= cards_left_r - CL_W'(1);
            shoe_low_r   <= (D_CL - cards_left_r + CL_W'(1)) >= PEN_CL;
          end
        end
        default: fill_idx_r <= '0;
      endcase
    end
  end

  // Registered handshake pulses and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      card_valid_r <= 1'b0;
      empty_err_r  <= 1'b0;
      busy_r       <= 1'b1;
    end else begin
      card_valid_r <= deal_go_s;
      empty_err_r  <= empty_go_s;
      busy_r       <= (next_state_s != ST_READY);
    end
  end

  assign card       = card_r;
  assign card_valid = card_valid_r;
  assign empty_err  = empty_err_r;
  assign busy       = busy_r;
  assign cards_left = cards_left_r;
  assign shoe_low   = shoe_low_r;

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe: one-deck and two-deck shoes checked against a Fisher-Yates reference.
module tb_card_shoe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        shuffle_start, deal_req;
  logic [15:0] seed;
  logic [7:0]  card;
  logic        card_valid, empty_err, busy, shoe_low;
  logic [5:0]  cards_left;

  logic        shuffle_start2, deal_req2;
  logic [15:0] seed2;
  logic [7:0]  card2;
  logic        card_valid2, empty_err2, busy2, shoe_low2;
  logic [6:0]  cards_left2;

  int tests  = 0;
  int failed = 0;

  logic [7:0] exp_seq [0:103];
  logic [7:0] got_seq [0:103];
  logic [7:0] ref_seq [0:103];
  int         pair_cnt [0:63];

  always #5 clk = ~clk;

  card_shoe #(.NUM_DECKS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .shuffle_start(shuffle_start), .seed(seed),
    .deal_req(deal_req), .card(card), .card_valid(card_valid), .empty_err(empty_err),
    .busy(busy), .cards_left(cards_left), .shoe_low(shoe_low)
  );

  card_shoe #(.NUM_DECKS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .shuffle_start(shuffle_start2), .seed(seed2),
    .deal_req(deal_req2), .card(card2), .card_valid(card_valid2), .empty_err(empty_err2),
    .busy(busy2), .cards_left(cards_left2), .shoe_low(shoe_low2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference shoe: ordered fill, then Fisher-Yates driven by the Galois LFSR.
  task automatic build_model(input int decks, input logic [15:0] s);
    int d, j;
    logic [15:0] l;
    logic [31:0] p;
    logic [7:0]  t;
    logic [3:0]  r;
    logic [1:0]  su;
    d = 52 * decks;
    for (int k = 0; k < d; k++) begin
      r  = 4'((k % 13) + 1);
      su = 2'((k / 13) % 4);
      exp_seq[k] = {2'b00, su, r};
    end
    l = s;
    for (int i = d - 1; i >= 1; i--) begin
      p = 32'(l) * 32'(i + 1);
      j = int'(p >> 16);
      t = exp_seq[i];
      exp_seq[i] = exp_seq[j];
      exp_seq[j] = t;
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
  endtask

  task automatic compare_seq(input int n, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) if (got_seq[k] !== exp_seq[k]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic check_pairs(input int n, input int copies, input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 64; a++) pair_cnt[a] = 0;
    for (int k = 0; k < n; k++) pair_cnt[got_seq[k][5:0]]++;
    for (int su = 0; su < 4; su++)
      for (int r = 1; r <= 13; r++)
        if (pair_cnt[su * 16 + r] != copies) bad++;
    chk(tag, bad, 0);
  endtask

  // Deal n cards from the one-deck shoe with deal_req held high; starts from a full shoe.
  task automatic deal1(input int n);
    deal_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      got_seq[k] = card;
      chk("d1_valid", card_valid, 1);
      chk("d1_left", cards_left, 51 - k);
      if (k == 37) chk("d1_low_before", shoe_low, 0);
      if (k == 38) chk("d1_low_at39", shoe_low, 1);
    end
    deal_req = 1'b0;
  endtask

  // Deal the whole two-deck shoe with deal_req held high.
  task automatic deal2();
    deal_req2 = 1'b1;
    for (int k = 0; k < 104; k++) begin
      @(negedge clk);
      got_seq[k] = card2;
      chk("d2_valid", card_valid2, 1);
      chk("d2_left", cards_left2, 103 - k);
      if (k == 76) chk("d2_low_before", shoe_low2, 0);
      if (k == 77) chk("d2_low_at78", shoe_low2, 1);
    end
    deal_req2 = 1'b0;
  endtask

  task automatic wait_ready1(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic shuffle2(input logic [15:0] s, output int cyc);
    seed2 = s;
    shuffle_start2 = 1'b1;
    @(negedge clk);
    shuffle_start2 = 1'b0;
    chk("d2_shuf_busy", busy2, 1);
    cyc = 1;
    while (busy2 === 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad;
    reset_n = 1'b0; shuffle_start = 1'b0; deal_req = 1'b0; seed = 16'h0000;
    shuffle_start2 = 1'b0; deal_req2 = 1'b0; seed2 = 16'h0000;
    #12;
    chk("rst_card", card, 8'h00);
    chk("rst_valid", card_valid, 0);
    chk("rst_err", empty_err, 0);
    chk("rst_busy", busy, 1);
    chk("rst_left", cards_left, 0);
    chk("rst_low", shoe_low, 0);
    chk("rst_busy2", busy2, 1);

    // Power-on fill and shuffle, then deal the full one-deck shoe.
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready1(cyc);
    chk("poweron_latency", cyc, 103);
    chk("poweron_left", cards_left, 52);
    chk("poweron_low", shoe_low, 0);
    build_model(1, 16'hACE1);
    deal1(52);
    chk("poweron_first_card", got_seq[0], exp_seq[0]);
    compare_seq(52, "poweron_seq");
    check_pairs(52, 1, "poweron_pairs");

    // 53rd request on an empty shoe.
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    chk("empty_err", empty_err, 1);
    chk("empty_no_valid", card_valid, 0);
    chk("empty_card_hold", card, got_seq[51]);
    chk("empty_left", cards_left, 0);
    @(negedge clk);
    chk("empty_err_pulse", empty_err, 0);

    // Two-deck shoe: full deal, double pairs, penetration point.
    cyc = 0;
    while (busy2 === 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("d2_ready", busy2, 0);
    chk("d2_full", cards_left2, 104);
    build_model(2, 16'hACE1);
    deal2();
    compare_seq(104, "d2_seq");
    check_pairs(104, 2, "d2_pairs");

    // Seed 16'h1234 twice on the two-deck shoe gives identical sequences.
    shuffle2(16'h1234, cyc);
    chk("d2_shuffle_latency", cyc, 208);
    build_model(2, 16'h1234);
    deal2();
    compare_seq(104, "d2_seed1234_seq");
    for (int k = 0; k < 104; k++) ref_seq[k] = got_seq[k];
    shuffle2(16'h1234, cyc);
    deal2();
    bad = 0;
    for (int k = 0; k < 104; k++) if (got_seq[k] !== ref_seq[k]) bad++;
    chk("d2_seed1234_repeat", bad, 0);

    // seed=0 falls back to SEED; requests while busy are dropped.
    seed = 16'h0000;
    shuffle_start = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    seed = 16'h1234;
    chk("s0_busy", busy, 1);
    chk("s0_left", cards_left, 0);
    cyc = 1;
    bad = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      deal_req      = ((cyc % 7) == 3);
      shuffle_start = ((cyc % 11) == 5);
      @(negedge clk);
      cyc++;
      if (card_valid !== 1'b0 || empty_err !== 1'b0) bad++;
    end
    deal_req = 1'b0;
    shuffle_start = 1'b0;
    chk("busy_drop_latency", cyc, 104);
    chk("busy_no_pulses", bad, 0);
    build_model(1, 16'hACE1);
    deal1(52);
    compare_seq(52, "seed0_seq");

    // Same-cycle shuffle_start and deal_req on the empty shoe: shuffle wins, no error.
    seed = 16'h0BAD;
    shuffle_start = 1'b1;
    deal_req = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    deal_req = 1'b0;
    chk("both_busy", busy, 1);
    chk("both_no_valid", card_valid, 0);
    chk("both_no_err", empty_err, 0);
    wait_ready1(cyc);
    chk("both_latency", cyc + 1, 104);

    // deal_req held for 10 cycles.
    build_model(1, 16'h0BAD);
    deal1(10);
    compare_seq(10, "held10_seq");
    @(negedge clk);
    chk("held10_stop", card_valid, 0);
    chk("held10_left", cards_left, 42);

    // Reset in the middle of the shuffle (i=30), then the power-on sequence again.
    seed = 16'h1234;
    shuffle_start = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    repeat (73) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_card", card, 8'h00);
    chk("midrst_valid", card_valid, 0);
    chk("midrst_err", empty_err, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_left", cards_left, 0);
    chk("midrst_low", shoe_low, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready1(cyc);
    chk("midrst_latency", cyc, 103);
    build_model(1, 16'hACE1);
    deal1(52);
    compare_seq(52, "midrst_seq");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/card_shoe.md
# card_shoe

Parametrised multi-deck card shoe for the blackjack datapath. Holds NUM_DECKS × 52 cards in a register array. Fills the array in order, then shuffles it in place with a Fisher-Yates pass driven by a 16-bit LFSR. Cards are dealt one at a time over a request/valid handshake. The block sits between the game controller, which issues shuffle and deal requests, and the hand/score logic, which consumes the 8-bit card codes. It also flags the penetration point so the controller can schedule a reshuffle.

## Interface
Parameters:
- NUM_DECKS, 1 — decks in the shoe, 1..8; D = 52·NUM_DECKS.
- PENETRATION, (3·D)/4 — cards dealt before shoe_low asserts; 1..D.
- SEED, 16'hACE1 — reset and fallback LFSR seed; must be non-zero.

Ports:
- clk  in  1  — single clock, rising edge.
- reset_n  in  1  — asynchronous, active-low reset.
- shuffle_start  in  1  — pulse; refill and reshuffle the shoe with `seed`.
- seed  in  16  — sampled when shuffle_start is accepted.
- deal_req  in  1  — pulse; request the next card.
- card  out  8  — {2'b00, suit[1:0], rank[3:0]}; rank 1=Ace .. 13=King; suit 0..3.
- card_valid  out  1  — one-cycle pulse; `card` is valid.
- empty_err  out  1  — one-cycle pulse; deal_req arrived with cards_left==0.
- busy  out  1  — filling or shuffling; requests are ignored except reset.
- cards_left  out  $clog2(D+1)  — undealt cards.
- shoe_low  out  1  — dealt count ≥ PENETRATION.

## Operation
- States: FILL, SHUFFLE, READY.
- Reset: state=FILL, LFSR=SEED, fill index=0, card=0, card_valid=0, empty_err=0, busy=1, cards_left=0, shoe_low=0.
- FILL:
  - One slot per cycle, k = 0..D-1; slot k gets rank (k mod 13)+1 and suit (k/13) mod 4.
  - Rank and suit are generated by wrap counters, not dividers.
  - After slot D-1 the block goes to SHUFFLE with i=D-1.
- SHUFFLE:
  - One swap per cycle: j = (lfsr·(i+1))>>16, which gives 0 ≤ j ≤ i.
  - Swap slot[i] with slot[j]; both are read and both written in the same cycle.
  - The LFSR steps once per swap; i decrements.
  - After the i=1 swap: deal pointer=0, cards_left=D, shoe_low=0, state → READY.
- LFSR: 16-bit Galois, right-shift, taps mask 16'hB400.
- READY:
  - busy=0.
  - deal_req with cards_left>0: card ← slot[ptr], card_valid=1 on the next cycle, ptr+1, cards_left−1.
  - deal_req with cards_left==0: empty_err=1 on the next cycle; card holds its last value and card_valid=0.
  - shuffle_start: LFSR ← seed (SEED if seed==0), state → FILL, busy=1 on the next cycle.
- Simultaneous shuffle_start and deal_req in READY: the shuffle wins, no card is dealt and no error is raised.
- shuffle_start and deal_req while busy are dropped silently; they are not queued.
- reset_n low at any time, mid-fill or mid-shuffle included, returns the block to the reset values immediately.
- shoe_low is registered and updates in the same cycle as cards_left.

## Timing
- Reset release to busy=0: D + (D−1) cycles (NUM_DECKS=1 → 103 cycles).
- shuffle_start to busy=0: 1 + D + (D−1) cycles.
- Deal latency: deal_req sampled at edge n → card_valid high for the cycle after edge n. Throughput is one card per cycle when deal_req is held high.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package card_pkg holds:
  - the state enum;
  - RANK_W=4, SUIT_W=2, CARDS_PER_DECK=52, RANKS=13;
  - LFSR_TAPS=16'hB400;
  - the card-field pack/unpack helpers.
- Sub-module lfsr16 provides load, step and a 16-bit value output, and is reused by other random sources.
- The card store is a 6-bit × D register array, not a RAM, because the shuffle swaps two slots per cycle.

## Test plan
- NUM_DECKS=1, SEED default: release reset → busy falls after exactly 103 cycles, cards_left=52. Deal 52 → each of the 52 rank/suit pairs appears once. The 53rd deal_req → empty_err pulse and no card_valid.
- NUM_DECKS=2: full deal → every pair appears twice. shoe_low rises with the 78th card_valid (cards_left=26).
- Same seed 16'h1234 applied twice via shuffle_start → identical 104-card sequences. seed=0 → sequence identical to the one produced with SEED.
- reset_n pulsed low during SHUFFLE at i=30 → outputs return to reset values immediately, then a full fill and shuffle runs, yielding the same sequence as after power-on.
- deal_req and shuffle_start asserted while busy → no card_valid, no empty_err, and the shuffle completes normally. Same-cycle shuffle_start and deal_req in READY → busy=1 next cycle and no card_valid.
- deal_req held high for 10 cycles in READY → 10 consecutive card_valid pulses, with cards_left decrementing by 1 each cycle.
